// File: rtl/ifu_pkg.sv
// Shared widths, fill FSM states and the line-response payload for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned OFFSET_WIDTH     = 4;
    localparam int unsigned TAG_WIDTH        = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LINE_WIDTH       = 128;
    localparam int unsigned BEAT_WIDTH       = 32;
    localparam int unsigned NUM_BEATS        = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_CNT_WIDTH   = $clog2(NUM_BEATS);
    localparam int unsigned FILL_COUNT_WIDTH = 16;

    // A line must split into whole beats; checked at elaboration by the fill controller.
    localparam bit LINE_BEAT_ALIGNED = (LINE_WIDTH % BEAT_WIDTH) == 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        DELIVER
    } fill_state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] line;
    } fill_rsp_t;

    function automatic logic [ADDR_WIDTH-1:0] lineAddr(input logic [TAG_WIDTH-1:0] tag);
        return {tag, OFFSET_WIDTH'(0)};
    endfunction

endpackage

// File: rtl/ifu_line_assembler.sv
// Beat counter and line buffer: places each memory beat into its slot, lowest beat first,
// and flags the beat that completes the line.
module ifu_line_assembler
    import ifu_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  beatValid,
    input  logic [BEAT_WIDTH-1:0] beatData,
    output logic [LINE_WIDTH-1:0] lineNext_c,
    output logic                  lastBeat_c
);

    logic [BEAT_CNT_WIDTH-1:0] beatCnt;
    logic [LINE_WIDTH-1:0]     lineBuf;

    // Line including the beat arriving this cycle, so the last beat can be delivered without a bubble.
    always_comb begin
        lineNext_c = lineBuf;
        if (beatValid) begin
            lineNext_c[32'(beatCnt) * BEAT_WIDTH +: BEAT_WIDTH] = beatData;
        end
    end

    assign lastBeat_c = beatValid && (beatCnt == BEAT_CNT_WIDTH'(NUM_BEATS - 1));

    always_ff @(posedge Clock) begin
        if (Rst) begin
            beatCnt <= '0;
            lineBuf <= '0;
        end else if (start) begin
            beatCnt <= '0;
        end else if (beatValid) begin
            lineBuf <= lineNext_c;
            beatCnt <= beatCnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifu_fill_ctrl.sv
// Miss-fill sequencer: takes one cache miss at a time, issues a line burst read on the memory
// port, assembles the beats and returns the line to the cache as a one-cycle pulse.
module ifu_fill_ctrl
    import ifu_pkg::*;
(
    input  logic                        Clock,
    input  logic                        Rst,
    input  logic [TAG_WIDTH-1:0]        cache_reqTagIn,
    input  logic                        cache_reqTagValidIn,
    output logic [TAG_WIDTH-1:0]        cache_rspTagOut,
    output logic [LINE_WIDTH-1:0]       cache_rspInsLineOut,
    output logic                        cache_rspInsLineValidOut,
    output logic [ADDR_WIDTH-1:0]       mem_reqAddrOut,
    output logic                        mem_reqValidOut,
    input  logic                        mem_reqReadyIn,
    input  logic [BEAT_WIDTH-1:0]       mem_rspDataIn,
    input  logic                        mem_rspValidIn,
    output logic                        busyOut,
    output logic [FILL_COUNT_WIDTH-1:0] fillCountOut,
    output logic                        errOut
);

    if (!LINE_BEAT_ALIGNED) begin : gLineBeatCheck
        $error("ifu_fill_ctrl: LINE_WIDTH is not a multiple of BEAT_WIDTH");
    end

    fill_state_t                 state, stateNext;
    logic [TAG_WIDTH-1:0]        latchedTag, latchedTagNext;
    fill_rsp_t                   rsp, rspNext;
    logic                        rspValidNext;
    logic                        reqValidNext;
    logic [ADDR_WIDTH-1:0]       reqAddrNext;
    logic                        busyNext;
    logic [FILL_COUNT_WIDTH-1:0] fillCountNext;
    logic                        errNext;

    logic                        handshake_c;
    logic                        beatValid_c;
    logic                        lastBeat_c;
    logic [LINE_WIDTH-1:0]       lineNext_c;

    assign handshake_c = mem_reqValidOut && mem_reqReadyIn;
    assign beatValid_c = mem_rspValidIn && (state == COLLECT);

    ifu_line_assembler uAssembler (
        .Clock      (Clock),
        .Rst        (Rst),
        .start      (handshake_c),
        .beatValid  (beatValid_c),
        .beatData   (mem_rspDataIn),
        .lineNext_c (lineNext_c),
        .lastBeat_c (lastBeat_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        stateNext      = state;
        latchedTagNext = latchedTag;
        rspNext        = rsp;
        reqAddrNext    = mem_reqAddrOut;
        fillCountNext  = fillCountOut;
        errNext        = errOut || (mem_rspValidIn && (state != COLLECT));

        unique case (state)
            IDLE: begin
                if (cache_reqTagValidIn) begin
                    latchedTagNext = cache_reqTagIn;
                    reqAddrNext    = lineAddr(cache_reqTagIn);
                    stateNext      = REQ;
                end
            end
            REQ: begin
                if (handshake_c) begin
                    stateNext = COLLECT;
                end
            end
            COLLECT: begin
                if (lastBeat_c) begin
                    rspNext.tag  = latchedTag;
                    rspNext.line = lineNext_c;
                    if (fillCountOut != '1) begin
                        fillCountNext = fillCountOut + 1'b1;
                    end
                    stateNext = DELIVER;
                end
            end
            DELIVER: begin
                // Skip one cycle so the cache has cleared the miss before IDLE looks again.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        reqValidNext = (stateNext == REQ);
        rspValidNext = (stateNext == DELIVER);
        busyNext     = (stateNext != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state                    <= IDLE;
            latchedTag               <= '0;
            rsp                      <= '0;
            cache_rspInsLineValidOut <= 1'b0;
            mem_reqValidOut          <= 1'b0;
            mem_reqAddrOut           <= '0;
            busyOut                  <= 1'b0;
            fillCountOut             <= '0;
            errOut                   <= 1'b0;
        end else begin
            state                    <= stateNext;
            latchedTag               <= latchedTagNext;
            rsp                      <= rspNext;
            cache_rspInsLineValidOut <= rspValidNext;
            mem_reqValidOut          <= reqValidNext;
            mem_reqAddrOut           <= reqAddrNext;
            busyOut                  <= busyNext;
            fillCountOut             <= fillCountNext;
            errOut                   <= errNext;
        end
    end

    assign cache_rspTagOut     = rsp.tag;
    assign cache_rspInsLineOut = rsp.line;

endmodule
